// File: rtl/pio_edge_irq.sv
// pio_edge_irq: parametrised Avalon-MM input PIO with edge-capture interrupts.
//
// Data path per input bit:
//   in_port -> synchroniser (SYNC_STAGES flops) -> debounce filter (filt)
//           -> one-cycle delayed copy (filt_dly) -> edge detect
//           -> sticky edge_capture (write-1-to-clear) -> masked, registered irq.
//
// Avalon access semantics: there is no handshake. The bus holds the slave
// for exactly one cycle per access; wr = chipselect & ~write_n is acted on at
// the same clock edge, and readdata is refreshed from the address decode on
// every edge (chipselect is ignored for reads), giving a fixed one-cycle read
// latency.
//
// Register map (word addresses):
//   0 data         RO   debounced input levels (filt)
//   1 reserved     RO   reads 0, writes ignored
//   2 irq_mask     RW
//   3 edge_capture RO bits, write 1 to clear a bit

module pio_edge_irq #(
    parameter int DATA_WIDTH      = 4,  // channel count, 1..32
    parameter int SYNC_STAGES     = 2,  // synchroniser depth, 2..4
    parameter int DEBOUNCE_CYCLES = 1,  // cycles a new level must persist, 1..65535
    parameter int EDGE_TYPE       = 0   // 0 rising, 1 falling, 2 any
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  irq
);

    // One extra bit over clog2 so DEBOUNCE_CYCLES = 1 still has a legal width
    // and the terminal count DEBOUNCE_CYCLES-1 always fits.
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                  filt_q, filt_d;
    logic [DATA_WIDTH-1:0]                  filt_dly_q, filt_dly_d;
    logic [DATA_WIDTH-1:0]                  irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0]                  edge_capture_q, edge_capture_d;
    logic [DATA_WIDTH-1:0]                  readdata_q, readdata_d;
    logic                                   irq_q, irq_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  wr;
    logic [DATA_WIDTH-1:0] sync_last;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] cap_clr;

    // Bus write strobe and the W1C clear vector for the capture register.
    always_comb begin
        wr      = chipselect & ~write_n;
        cap_clr = '0;
        if (wr && (address == ADDR_CAP)) begin
            cap_clr = writedata;
        end
    end

    // Synchroniser shift chain: stage 0 samples the raw pins.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        sync_last = sync_q[SYNC_STAGES-1];
    end

    // Per-bit debounce: a differing level must be seen DEBOUNCE_CYCLES
    // consecutive cycles before filt follows it. Any cycle where the
    // synchronised input agrees with filt restarts the count, so a glitch
    // shorter than the window never propagates.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (sync_last[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync_last[i];
                cnt_d[i]  = '0;
            end else if (cnt_q[i] != CNT_SAT) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Delayed copy of the filtered level, used only for edge detection.
    always_comb begin
        filt_dly_d = filt_q;
    end

    // Edge detector, selected at elaboration time.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = filt_q & ~filt_dly_q;
            1:       edge_det = ~filt_q & filt_dly_q;
            default: edge_det = filt_q ^ filt_dly_q;
        endcase
    end

    // Capture is sticky; a fresh edge beats a same-cycle W1C so an event
    // arriving while software clears the bit is never lost.
    always_comb begin
        edge_capture_d = edge_det | (edge_capture_q & ~cap_clr);
    end

    // Interrupt mask register, plain read/write.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr && (address == ADDR_MASK)) begin
            irq_mask_d = writedata;
        end
    end

    // Interrupt is the OR of pending-and-enabled bits; masking drops irq
    // without touching the captured bits.
    always_comb begin
        irq_d = |(edge_capture_q & irq_mask_q);
    end

    // Read mux, evaluated every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = filt_q;
            ADDR_RSVD: readdata_d = '0;
            ADDR_MASK: readdata_d = irq_mask_q;
            ADDR_CAP:  readdata_d = edge_capture_q;
            default:   readdata_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Input synchroniser and debounce state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
        end
    end

    // Software-visible registers and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_irq.sv
// Testbench for pio_edge_irq: five instances cover the default build, an
// 8-cycle debounce, falling and any-edge modes, and a 32-bit build. Each
// instance has its own chipselect and input port; address/write bus shared.

module tb_pio_edge_irq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared bus
  logic [1:0]  address   = 2'd0;
  logic        write_n   = 1'b1;
  logic [31:0] writedata = '0;
  logic [4:0]  cs        = '0;

  // per-instance signals
  logic [3:0]  in_def = '0, in_deb = '0, in_fall = '0, in_any = '0;
  logic [31:0] in_wide = '0;
  logic [3:0]  rd_def, rd_deb, rd_fall, rd_any;
  logic [31:0] rd_wide;
  logic        irq_def, irq_deb, irq_fall, irq_any, irq_wide;

  pio_edge_irq u_def (
    .clk(clk), .reset(rst), .address(address), .chipselect(cs[0]),
    .write_n(write_n), .writedata(writedata[3:0]), .in_port(in_def),
    .readdata(rd_def), .irq(irq_def)
  );

  pio_edge_irq #(.DEBOUNCE_CYCLES(8)) u_deb (
    .clk(clk), .reset(rst), .address(address), .chipselect(cs[1]),
    .write_n(write_n), .writedata(writedata[3:0]), .in_port(in_deb),
    .readdata(rd_deb), .irq(irq_deb)
  );

  pio_edge_irq #(.EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(rst), .address(address), .chipselect(cs[2]),
    .write_n(write_n), .writedata(writedata[3:0]), .in_port(in_fall),
    .readdata(rd_fall), .irq(irq_fall)
  );

  pio_edge_irq #(.EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(rst), .address(address), .chipselect(cs[3]),
    .write_n(write_n), .writedata(writedata[3:0]), .in_port(in_any),
    .readdata(rd_any), .irq(irq_any)
  );

  pio_edge_irq #(.DATA_WIDTH(32)) u_wide (
    .clk(clk), .reset(rst), .address(address), .chipselect(cs[4]),
    .write_n(write_n), .writedata(writedata), .in_port(in_wide),
    .readdata(rd_wide), .irq(irq_wide)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drive/sample happens at the falling edge, away from the active edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input int sel, input logic [1:0] a, input logic [31:0] d);
    cs        = 5'(1 << sel);
    address   = a;
    write_n   = 1'b0;
    writedata = d;
    @(negedge clk);
    cs      = '0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    @(negedge clk);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    tick(3);
    push_exp("reset_rd_def", 32'h0);   chk({28'b0, rd_def});
    push_exp("reset_irq_def", 32'h0);  chk({31'b0, irq_def});
    push_exp("reset_rd_wide", 32'h0);  chk(rd_wide);
    rst = 1'b0;
    tick(2);

    // ---- latency, defaults ----
    wr_reg(0, 2'd2, 32'h1);
    rd(2'd2);
    push_exp("mask_readback", 32'h1);  chk({28'b0, rd_def});
    address = 2'd3;
    in_def  = 4'h1;
    tick(4);                           // edges 1..4
    push_exp("lat_irq_e4", 32'h0);     chk({31'b0, irq_def});
    push_exp("lat_cap_rd_e4", 32'h0);  chk({28'b0, rd_def});
    tick(1);                           // edge 5
    push_exp("lat_irq_e5", 32'h1);     chk({31'b0, irq_def});
    push_exp("lat_cap_rd_e5", 32'h1);  chk({28'b0, rd_def});
    rd(2'd0);
    push_exp("lat_data", 32'h1);       chk({28'b0, rd_def});
    wr_reg(0, 2'd2, 32'h0);
    tick(1);
    push_exp("mask_off_irq", 32'h0);   chk({31'b0, irq_def});
    rd(2'd3);
    push_exp("mask_keeps_cap", 32'h1); chk({28'b0, rd_def});

    // ---- W1C and race ----
    in_def = 4'hF;
    tick(6);
    rd(2'd3);
    push_exp("cap_all", 32'hF);        chk({28'b0, rd_def});
    wr_reg(0, 2'd3, 32'h5);
    rd(2'd3);
    push_exp("w1c_5", 32'hA);          chk({28'b0, rd_def});
    in_def = 4'hE;
    tick(6);
    rd(2'd3);
    push_exp("fall_ignored", 32'hA);   chk({28'b0, rd_def});
    in_def = 4'hF;
    tick(3);                           // edges 1..3; capture sets on edge 4
    wr_reg(0, 2'd3, 32'h1);            // clear lands on edge 4 too
    rd(2'd3);
    push_exp("race_edge_wins", 32'hB); chk({28'b0, rd_def});

    // ---- reset mid-traffic ----
    in_def = 4'hB;
    tick(6);
    in_def = 4'hF;
    tick(6);
    rd(2'd3);
    push_exp("cap_F_pre_reset", 32'hF); chk({28'b0, rd_def});
    wr_reg(0, 2'd2, 32'hF);
    tick(1);
    push_exp("irq_pre_reset", 32'h1);  chk({31'b0, irq_def});
    rst = 1'b1;
    #1;
    push_exp("async_rst_rd", 32'h0);   chk({28'b0, rd_def});
    push_exp("async_rst_irq", 32'h0);  chk({31'b0, irq_def});
    @(negedge clk);
    rst = 1'b0;
    rd(2'd3);
    push_exp("post_rst_cap", 32'h0);   chk({28'b0, rd_def});
    rd(2'd2);
    push_exp("post_rst_mask", 32'h0);  chk({28'b0, rd_def});
    push_exp("post_rst_irq", 32'h0);   chk({31'b0, irq_def});
    tick(6);

    // ---- debounce (8 cycles) ----
    in_deb = 4'h1;
    tick(7);
    in_deb = 4'h0;
    tick(20);
    rd(2'd0);
    push_exp("deb7_data", 32'h0);      chk({28'b0, rd_deb});
    rd(2'd3);
    push_exp("deb7_cap", 32'h0);       chk({28'b0, rd_deb});
    in_deb = 4'h1;
    tick(8);
    in_deb = 4'h0;
    tick(20);
    rd(2'd3);
    push_exp("deb8_cap", 32'h1);       chk({28'b0, rd_deb});
    wr_reg(1, 2'd3, 32'h1);
    rd(2'd3);
    push_exp("deb_clear", 32'h0);      chk({28'b0, rd_deb});
    for (int i = 0; i < 100; i++) begin
      in_deb = ~in_deb;
      tick(1);
    end
    in_deb = 4'h0;
    tick(20);
    rd(2'd3);
    push_exp("glitch_cap", 32'h0);     chk({28'b0, rd_deb});
    rd(2'd0);
    push_exp("glitch_data", 32'h0);    chk({28'b0, rd_deb});

    // ---- edge modes on bit 2 ----
    in_fall = 4'h4;
    in_any  = 4'h4;
    tick(6);
    rd(2'd3);
    push_exp("fall_on_rise", 32'h0);   push_exp("any_on_rise", 32'h4);
    chk({28'b0, rd_fall});             chk({28'b0, rd_any});
    wr_reg(2, 2'd3, 32'hF);
    wr_reg(3, 2'd3, 32'hF);
    rd(2'd3);
    push_exp("fall_cleared", 32'h0);   push_exp("any_cleared", 32'h0);
    chk({28'b0, rd_fall});             chk({28'b0, rd_any});
    in_fall = 4'h0;
    in_any  = 4'h0;
    tick(6);
    rd(2'd3);
    push_exp("fall_on_fall", 32'h4);   push_exp("any_on_fall", 32'h4);
    chk({28'b0, rd_fall});             chk({28'b0, rd_any});

    // ---- 32-bit build ----
    in_wide = 32'h8000_0001;
    tick(6);
    rd(2'd0);
    push_exp("wide_data", 32'h8000_0001); chk(rd_wide);
    rd(2'd3);
    push_exp("wide_cap", 32'h8000_0001);  chk(rd_wide);
    rd(2'd1);
    push_exp("wide_rsvd", 32'h0);         chk(rd_wide);
    wr_reg(4, 2'd0, 32'hFFFF_FFFF);
    wr_reg(4, 2'd1, 32'hFFFF_FFFF);
    rd(2'd0);
    push_exp("wide_data_ro", 32'h8000_0001); chk(rd_wide);
    rd(2'd1);
    push_exp("wide_rsvd_ro", 32'h0);      chk(rd_wide);
    rd(2'd2);
    push_exp("wide_mask_untouched", 32'h0); chk(rd_wide);
    push_exp("wide_irq_masked", 32'h0);   chk({31'b0, irq_wide});

    // ---- report ----
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
